// File: rtl/decode_ctrl_stage_pkg.sv
// Shared opcode, aluop, branch-select and FSM encodings for the ID stage.
// Imported by decode_ctrl_comb and decode_ctrl_stage.
package decode_ctrl_stage_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_I   = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_BR  = 2'b11;

  localparam int BR_BEQ  = 0;
  localparam int BR_BNE  = 1;
  localparam int BR_BLT  = 2;
  localparam int BR_BGE  = 3;
  localparam int BR_BLTU = 4;
  localparam int BR_BGEU = 5;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_BUBBLE = 2'd2
  } state_e;

  typedef struct packed {
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
    logic       lui;
    logic       u_type;
    logic       jal;
    logic       jalr;
    logic [5:0] br_sel;
    logic       illegal;
    logic       is_muldiv;
  } ctrl_t;

  function automatic logic [31:0] imm32(input logic [31:0] i);
    logic [31:0] r;
    r = '0;
    unique case (i[6:0])
      OP_I_TYPE, OP_LOAD, OP_JALR:
        r = {{20{i[31]}}, i[31:20]};
      OP_STORE:
        r = {{20{i[31]}}, i[31:25], i[11:7]};
      OP_B_TYPE:
        r = {{19{i[31]}}, i[31], i[7],
             i[30:25], i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        r = {i[31:12], 12'b0};
      OP_JAL:
        r = {{11{i[31]}}, i[31], i[19:12],
             i[20], i[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// Fetch-side and EX-side handshake bundle of the ID stage.
// slave = the stage itself, master = its environment.
interface decode_ctrl_stage_if #(
  parameter int XLEN      = 32,
  parameter int RW_TYPE_W = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [XLEN-1:0]      in_pc;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [4:0]           out_rd;
  logic [4:0]           out_rs1;
  logic [4:0]           out_rs2;
  logic [XLEN-1:0]      out_imm;
  logic                 out_memread;
  logic                 out_memtoreg;
  logic                 out_memwrite;
  logic                 out_alusrc;
  logic                 out_regwrite;
  logic [1:0]           out_aluop;
  logic                 out_lui;
  logic                 out_u_type;
  logic                 out_jal;
  logic                 out_jalr;
  logic [5:0]           out_br_sel;
  logic [RW_TYPE_W-1:0] out_rw_type;
  logic                 out_illegal;
  logic                 out_is_muldiv;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rd,
    output out_rs1, out_rs2, out_imm, out_memread,
    output out_memtoreg, out_memwrite, out_alusrc,
    output out_regwrite, out_aluop, out_lui, out_u_type,
    output out_jal, out_jalr, out_br_sel, out_rw_type,
    output out_illegal, out_is_muldiv
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rd,
    input  out_rs1, out_rs2, out_imm, out_memread,
    input  out_memtoreg, out_memwrite, out_alusrc,
    input  out_regwrite, out_aluop, out_lui, out_u_type,
    input  out_jal, out_jalr, out_br_sel, out_rw_type,
    input  out_illegal, out_is_muldiv
  );
endinterface

// File: rtl/decode_ctrl_stage_comb.sv
// Pure combinational RV32I control decoder: bundle, imm, rs-used.
// DECODE_MEXT_EN enables M-extension (funct7=0000001) decode.
module decode_ctrl_comb
  import decode_ctrl_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm,
  output logic            rs1_used,
  output logic            rs2_used
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm    = XLEN'($signed(imm32(instr)));

  // control bundle and register-read flags by opcode
  always_comb begin
    ctrl     = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (opcode)
      OP_R_TYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_R;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        if (funct7 == F7_MULDIV) begin
`ifdef DECODE_MEXT_EN
          ctrl.is_muldiv = 1'b1;
`else
          ctrl.illegal = 1'b1;
`endif
        end
      end
      OP_I_TYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALUOP_I;
        rs1_used      = 1'b1;
      end
      OP_LOAD: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.aluop    = ALUOP_MEM;
        rs1_used      = 1'b1;
      end
      OP_STORE: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.aluop    = ALUOP_MEM;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      OP_B_TYPE: begin
        ctrl.aluop = ALUOP_BR;
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
        unique case (funct3)
          3'b000: ctrl.br_sel[BR_BEQ]  = 1'b1;
          3'b001: ctrl.br_sel[BR_BNE]  = 1'b1;
          3'b100: ctrl.br_sel[BR_BLT]  = 1'b1;
          3'b101: ctrl.br_sel[BR_BGE]  = 1'b1;
          3'b110: ctrl.br_sel[BR_BLTU] = 1'b1;
          3'b111: ctrl.br_sel[BR_BGEU] = 1'b1;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        ctrl.regwrite = 1'b1;
        ctrl.jal      = 1'b1;
      end
      OP_JALR: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.jalr     = 1'b1;
        rs1_used      = 1'b1;
      end
      OP_LUI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.lui      = 1'b1;
        ctrl.u_type   = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.u_type   = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // an illegal op must not write state, branch or stall anyone
    if (ctrl.illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      rs1_used     = 1'b0;
      rs2_used     = 1'b0;
    end
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered ID stage: decode, valid/ready, flush, load-use bubbles.
// DECODE_MEXT_EN enables M-extension decode in decode_ctrl_comb.
module decode_ctrl_stage
  import decode_ctrl_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int LOAD_BUBBLES = 1,
  parameter int RW_TYPE_W    = 3
) (
  input logic                 clk,
  input logic                 rst,
  decode_ctrl_stage_if.slave  io
);

  localparam logic [1:0] LB_CNT = 2'(LOAD_BUBBLES);

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic [XLEN-1:0]      imm_q, imm_d;
  logic [4:0]           rd_q, rd_d;
  logic [4:0]           rs1_q, rs1_d;
  logic [4:0]           rs2_q, rs2_d;
  logic [RW_TYPE_W-1:0] rw_q, rw_d;

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic            dec_rs1_used;
  logic            dec_rs2_used;
  logic            hazard;
  logic            in_ready;
  logic            accept;

  decode_ctrl_comb #(.XLEN(XLEN)) u_comb (
    .instr    (io.in_instr),
    .ctrl     (dec_ctrl),
    .imm      (dec_imm),
    .rs1_used (dec_rs1_used),
    .rs2_used (dec_rs2_used)
  );

  // load-use check of the incoming op against the held bundle
  always_comb begin
    hazard = (state_q == ST_FULL) && io.in_valid
          && ctrl_q.memread && (rd_q != 5'd0)
          && ((dec_rs1_used && io.in_instr[19:15] == rd_q)
           || (dec_rs2_used && io.in_instr[24:20] == rd_q));
    if (LOAD_BUBBLES == 0) hazard = 1'b0;
  end

  // ready: blocked in reset, flush, stall, or while bubbles remain
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      ST_EMPTY:  in_ready = 1'b1;
      ST_FULL:   in_ready = io.out_ready && !hazard;
      ST_BUBBLE: in_ready = (cnt_q == 2'd1);
      default:   in_ready = 1'b0;
    endcase
    if (rst || io.flush) in_ready = 1'b0;
  end

  assign accept = io.in_valid && in_ready;

  // next state and bubble counter; flush overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (io.out_ready) begin
          if (hazard) begin
            state_d = ST_BUBBLE;
            cnt_d   = LB_CNT;
          end else if (accept) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      ST_BUBBLE: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          cnt_d   = 2'd0;
          state_d = accept ? ST_FULL : ST_EMPTY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        cnt_d   = 2'd0;
      end
    endcase
    if (io.flush) begin
      state_d = ST_EMPTY;
      cnt_d   = 2'd0;
    end
  end

  // output bundle capture on accept, otherwise hold
  always_comb begin
    ctrl_d = ctrl_q;
    pc_d   = pc_q;
    imm_d  = imm_q;
    rd_d   = rd_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rw_d   = rw_q;
    if (accept) begin
      ctrl_d = dec_ctrl;
      pc_d   = io.in_pc;
      imm_d  = dec_imm;
      rd_d   = io.in_instr[11:7];
      rs1_d  = io.in_instr[19:15];
      rs2_d  = io.in_instr[24:20];
      rw_d   = RW_TYPE_W'(io.in_instr[14:12]);
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      cnt_q   <= 2'd0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rw_q    <= rw_d;
    end
  end

  assign io.in_ready      = in_ready;
  assign io.out_valid     = (state_q == ST_FULL);
  assign io.out_pc        = pc_q;
  assign io.out_rd        = rd_q;
  assign io.out_rs1       = rs1_q;
  assign io.out_rs2       = rs2_q;
  assign io.out_imm       = imm_q;
  assign io.out_memread   = ctrl_q.memread;
  assign io.out_memtoreg  = ctrl_q.memtoreg;
  assign io.out_memwrite  = ctrl_q.memwrite;
  assign io.out_alusrc    = ctrl_q.alusrc;
  assign io.out_regwrite  = ctrl_q.regwrite;
  assign io.out_aluop     = ctrl_q.aluop;
  assign io.out_lui       = ctrl_q.lui;
  assign io.out_u_type    = ctrl_q.u_type;
  assign io.out_jal       = ctrl_q.jal;
  assign io.out_jalr      = ctrl_q.jalr;
  assign io.out_br_sel    = ctrl_q.br_sel;
  assign io.out_rw_type   = rw_q;
  assign io.out_illegal   = ctrl_q.illegal;
  assign io.out_is_muldiv = ctrl_q.is_muldiv;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage (LOAD_BUBBLES=1 and =2).
// Expectations for the mul case follow DECODE_MEXT_EN.
module tb_decode_ctrl_stage;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_ADD5 = 32'h00528333;
  localparam logic [31:0] I_LW0  = 32'h0000A003;
  localparam logic [31:0] I_ADD0 = 32'h00000333;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_MUL  = 32'h022081B3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  decode_ctrl_stage_if #(.XLEN(32), .RW_TYPE_W(3)) if1 ();
  decode_ctrl_stage_if #(.XLEN(32), .RW_TYPE_W(3)) if2 ();

  decode_ctrl_stage #(
    .XLEN(32), .LOAD_BUBBLES(1), .RW_TYPE_W(3)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .io  (if1)
  );

  decode_ctrl_stage #(
    .XLEN(32), .LOAD_BUBBLES(2), .RW_TYPE_W(3)
  ) u_dut2 (
    .clk (clk),
    .rst (rst),
    .io  (if2)
  );

  task automatic test_reset();
    if1.in_valid = 1'b1;
    if1.in_instr = I_ADD;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (if1.in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_in_ready: got %b want 0", if1.in_ready);
    end
    vec_cnt++;
    if (if1.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_out_valid: got %b want 0", if1.out_valid);
    end
    vec_cnt++;
    if (if1.out_regwrite !== 1'b0 || if1.out_imm !== 32'h0) begin
      err_cnt++;
      $display("FAIL rst_regs: regwrite %b imm %h want 0/0",
               if1.out_regwrite, if1.out_imm);
    end
    vec_cnt++;
    if (if2.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_out_valid2: got %b want 0", if2.out_valid);
    end
    if1.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (if1.in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL rst_release_ready: got %b want 1", if1.in_ready);
    end
  endtask

  task automatic test_add();
    if1.in_valid  = 1'b1;
    if1.in_instr  = I_ADD;
    if1.in_pc     = 32'h100;
    if1.out_ready = 1'b1;
    #1;
    vec_cnt++;
    if (if1.in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL add_in_ready: got %b want 1", if1.in_ready);
    end
    @(negedge clk);
    if1.in_valid = 1'b0;
    vec_cnt++;
    if (if1.out_valid !== 1'b1 || if1.out_regwrite !== 1'b1) begin
      err_cnt++;
      $display("FAIL add_valid_rw: got %b/%b want 1/1",
               if1.out_valid, if1.out_regwrite);
    end
    vec_cnt++;
    if (if1.out_aluop !== 2'b10 || if1.out_illegal !== 1'b0) begin
      err_cnt++;
      $display("FAIL add_aluop_ill: got %b/%b want 10/0",
               if1.out_aluop, if1.out_illegal);
    end
    vec_cnt++;
    if (if1.out_rd !== 5'd3 || if1.out_rs1 !== 5'd1
        || if1.out_rs2 !== 5'd2) begin
      err_cnt++;
      $display("FAIL add_regs: got %0d,%0d,%0d want 3,1,2",
               if1.out_rd, if1.out_rs1, if1.out_rs2);
    end
    vec_cnt++;
    if (if1.out_pc !== 32'h100) begin
      err_cnt++;
      $display("FAIL add_pc: got %h want 100", if1.out_pc);
    end
    @(negedge clk);
    vec_cnt++;
    if (if1.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL add_drain: got %b want 0", if1.out_valid);
    end
  endtask

  task automatic test_load_use1();
    if1.in_valid = 1'b1;
    if1.in_instr = I_LW;
    if1.in_pc    = 32'h104;
    @(negedge clk);
    if1.in_instr = I_ADD5;
    #1;
    vec_cnt++;
    if (if1.out_valid !== 1'b1 || if1.out_memread !== 1'b1) begin
      err_cnt++;
      $display("FAIL lu1_lw: valid %b memread %b want 1/1",
               if1.out_valid, if1.out_memread);
    end
    vec_cnt++;
    if (if1.out_rw_type !== 3'b010 || if1.out_rd !== 5'd5) begin
      err_cnt++;
      $display("FAIL lu1_rw_rd: got %b/%0d want 010/5",
               if1.out_rw_type, if1.out_rd);
    end
    vec_cnt++;
    if (if1.in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL lu1_hz_ready: got %b want 0", if1.in_ready);
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL lu1_bubble: valid %b ready %b want 0/1",
               if1.out_valid, if1.in_ready);
    end
    @(negedge clk);
    if1.in_valid = 1'b0;
    vec_cnt++;
    if (if1.out_valid !== 1'b1 || if1.out_rd !== 5'd6
        || if1.out_memread !== 1'b0) begin
      err_cnt++;
      $display("FAIL lu1_add: valid %b rd %0d mr %b want 1/6/0",
               if1.out_valid, if1.out_rd, if1.out_memread);
    end
    @(negedge clk);
  endtask

  task automatic test_load_use2();
    if2.in_valid  = 1'b1;
    if2.in_instr  = I_LW;
    if2.in_pc     = 32'h300;
    if2.out_ready = 1'b1;
    @(negedge clk);
    if2.in_instr = I_ADD5;
    #1;
    vec_cnt++;
    if (if2.out_valid !== 1'b1 || if2.in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL lu2_lw: valid %b ready %b want 1/0",
               if2.out_valid, if2.in_ready);
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if (if2.out_valid !== 1'b0 || if2.in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL lu2_bub1: valid %b ready %b want 0/0",
               if2.out_valid, if2.in_ready);
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if (if2.out_valid !== 1'b0 || if2.in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL lu2_bub2: valid %b ready %b want 0/1",
               if2.out_valid, if2.in_ready);
    end
    @(negedge clk);
    if2.in_valid = 1'b0;
    vec_cnt++;
    if (if2.out_valid !== 1'b1 || if2.out_rd !== 5'd6) begin
      err_cnt++;
      $display("FAIL lu2_add: valid %b rd %0d want 1/6",
               if2.out_valid, if2.out_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_x0();
    if1.in_valid = 1'b1;
    if1.in_instr = I_LW0;
    @(negedge clk);
    if1.in_instr = I_ADD0;
    #1;
    vec_cnt++;
    if (if1.in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL x0_no_hz: ready %b want 1", if1.in_ready);
    end
    vec_cnt++;
    if (if1.out_regwrite !== 1'b1 || if1.out_rd !== 5'd0) begin
      err_cnt++;
      $display("FAIL x0_lw: rw %b rd %0d want 1/0",
               if1.out_regwrite, if1.out_rd);
    end
    @(negedge clk);
    if1.in_valid = 1'b0;
    vec_cnt++;
    if (if1.out_valid !== 1'b1 || if1.out_rd !== 5'd6) begin
      err_cnt++;
      $display("FAIL x0_add: valid %b rd %0d want 1/6",
               if1.out_valid, if1.out_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_hold_flush();
    if1.in_valid = 1'b1;
    if1.in_instr = I_BEQ;
    if1.in_pc    = 32'h200;
    @(negedge clk);
    if1.in_instr  = I_ADD;
    if1.in_pc     = 32'h204;
    if1.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (if1.out_valid !== 1'b1 || if1.out_pc !== 32'h200) begin
        err_cnt++;
        $display("FAIL hold_vp[%0d]: valid %b pc %h want 1/200",
                 i, if1.out_valid, if1.out_pc);
      end
      vec_cnt++;
      if (if1.out_br_sel !== 6'b000001 || if1.out_imm !== 32'd8) begin
        err_cnt++;
        $display("FAIL hold_br[%0d]: br %b imm %h want 000001/8",
                 i, if1.out_br_sel, if1.out_imm);
      end
      vec_cnt++;
      if (if1.in_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL hold_ready[%0d]: got %b want 0",
                 i, if1.in_ready);
      end
      @(negedge clk);
      #1;
    end
    if1.flush     = 1'b1;
    if1.out_ready = 1'b1;
    #1;
    vec_cnt++;
    if (if1.in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_ready: got %b want 0", if1.in_ready);
    end
    @(negedge clk);
    if1.flush    = 1'b0;
    if1.in_valid = 1'b0;
    vec_cnt++;
    if (if1.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_valid: got %b want 0", if1.out_valid);
    end
  endtask

  task automatic test_illegal();
    if1.in_valid = 1'b1;
    if1.in_instr = 32'h0;
    @(negedge clk);
    if1.in_valid = 1'b0;
    vec_cnt++;
    if (if1.out_valid !== 1'b1 || if1.out_illegal !== 1'b1) begin
      err_cnt++;
      $display("FAIL ill_flag: valid %b ill %b want 1/1",
               if1.out_valid, if1.out_illegal);
    end
    vec_cnt++;
    if (if1.out_regwrite !== 1'b0 || if1.out_memwrite !== 1'b0
        || if1.out_memread !== 1'b0) begin
      err_cnt++;
      $display("FAIL ill_ctrl: rw %b mw %b mr %b want 0/0/0",
               if1.out_regwrite, if1.out_memwrite, if1.out_memread);
    end
    @(negedge clk);
  endtask

  task automatic test_muldiv();
    if1.in_valid = 1'b1;
    if1.in_instr = I_MUL;
    @(negedge clk);
    if1.in_valid = 1'b0;
`ifdef DECODE_MEXT_EN
    vec_cnt++;
    if (if1.out_is_muldiv !== 1'b1 || if1.out_illegal !== 1'b0) begin
      err_cnt++;
      $display("FAIL mul_en: md %b ill %b want 1/0",
               if1.out_is_muldiv, if1.out_illegal);
    end
    vec_cnt++;
    if (if1.out_regwrite !== 1'b1 || if1.out_aluop !== 2'b10) begin
      err_cnt++;
      $display("FAIL mul_en_ctrl: rw %b aluop %b want 1/10",
               if1.out_regwrite, if1.out_aluop);
    end
`else
    vec_cnt++;
    if (if1.out_is_muldiv !== 1'b0 || if1.out_illegal !== 1'b1) begin
      err_cnt++;
      $display("FAIL mul_dis: md %b ill %b want 0/1",
               if1.out_is_muldiv, if1.out_illegal);
    end
    vec_cnt++;
    if (if1.out_regwrite !== 1'b0) begin
      err_cnt++;
      $display("FAIL mul_dis_rw: got %b want 0", if1.out_regwrite);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_stall();
    if2.in_valid = 1'b1;
    if2.in_instr = I_LW;
    @(negedge clk);
    if2.in_instr = I_ADD5;
    @(negedge clk);
    vec_cnt++;
    if (if2.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL rs_in_bubble: valid %b want 0", if2.out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (if2.out_valid !== 1'b0 || if2.in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL rs_during: valid %b ready %b want 0/0",
               if2.out_valid, if2.in_ready);
    end
    rst          = 1'b0;
    if2.in_valid = 1'b0;
    #1;
    vec_cnt++;
    if (if2.in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL rs_ready: got %b want 1", if2.in_ready);
    end
    vec_cnt++;
    if (if2.out_rd !== 5'd0 || if2.out_memread !== 1'b0) begin
      err_cnt++;
      $display("FAIL rs_cleared: rd %0d mr %b want 0/0",
               if2.out_rd, if2.out_memread);
    end
    @(negedge clk);
    vec_cnt++;
    if (if2.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL rs_no_out: valid %b want 0", if2.out_valid);
    end
    if2.in_valid = 1'b1;
    if2.in_instr = I_ADD5;
    @(negedge clk);
    if2.in_valid = 1'b0;
    vec_cnt++;
    if (if2.out_valid !== 1'b1 || if2.out_rd !== 5'd6) begin
      err_cnt++;
      $display("FAIL rs_resume: valid %b rd %0d want 1/6",
               if2.out_valid, if2.out_rd);
    end
  endtask

  initial begin
    if1.in_valid  = 1'b0;
    if1.in_instr  = '0;
    if1.in_pc     = '0;
    if1.flush     = 1'b0;
    if1.out_ready = 1'b1;
    if2.in_valid  = 1'b0;
    if2.in_instr  = '0;
    if2.in_pc     = '0;
    if2.flush     = 1'b0;
    if2.out_ready = 1'b1;
    test_reset();
    test_add();
    test_load_use1();
    test_load_use2();
    test_x0();
    test_hold_flush();
    test_illegal();
    test_muldiv();
    test_reset_stall();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
- Pipelined successor to the combinational main control decoder; sits between IF/ID and the ID/EX boundary.
- Decodes a 32-bit RV32I instruction into the full control bundle, immediate and register indices, and registers them in one output stage.
- Uses a valid/ready handshake and supports flush.
- Detects load-use hazards against the instruction it holds and inserts a parametrised number of bubbles.

Parameters:
- XLEN, 32: width of pc and imm outputs; 32 or 64; imm is sign-extended to XLEN.
- LOAD_BUBBLES, 1: bubbles inserted on a load-use hazard; 0 disables hazard stalling; max 3.
- RW_TYPE_W, 3: width of rw_type, carried from funct3.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction valid from fetch.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction pc.
- flush  in  1  kill the held instruction and any pending bubbles (branch/jump redirect).
- out_valid  out  1  output bundle valid.
- out_ready  in  1  EX stage accepts the bundle.
- out_pc  out  XLEN  registered pc.
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_imm  out  XLEN  decoded immediate (I/S/B/U/J by opcode).
- out_memread, out_memtoreg, out_memwrite, out_alusrc, out_regwrite  out  1 each.
- out_aluop  out  2  {r_type|branch, i_type|branch}.
- out_lui, out_u_type, out_jal, out_jalr  out  1 each.
- out_br_sel  out  6  one-hot {bgeu,bltu,bge,blt,bne,beq}.
- out_rw_type  out  RW_TYPE_W  funct3.
- out_illegal  out  1  unknown opcode or reserved branch funct3.
- out_is_muldiv  out  1  M-extension op (see Optional Feature).

Behaviour:
- Decode is combinational from in_instr and is captured into the output register on an accept (in_valid & in_ready).
- Latency: 1 cycle from accept to out_valid.
- Reset: every output register clears to 0; state clears to EMPTY; bubble counter clears to 0.
- in_ready stays 0 during reset.
- FSM states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - BUBBLE: out_valid=0, input blocked.
- EMPTY transitions: accept → FULL; otherwise stay.
- FULL transitions:
  - out_ready & accept & no hazard → FULL (new bundle).
  - out_ready & hazard → BUBBLE; counter=LOAD_BUBBLES; the incoming instruction is NOT accepted.
  - out_ready & no accept → EMPTY.
  - !out_ready → hold every output stable.
- BUBBLE transitions: decrement counter each cycle; when counter reaches 1, in_ready=1 and an accept → FULL; with no accept → EMPTY.
- in_ready = !rst & !flush & (state==EMPTY | (state==FULL & out_ready & !hazard) | (state==BUBBLE & cnt==1)).
- Hazard condition: held bundle has memread=1 and rd≠0, and the incoming instruction reads that rd.
  - rs1 is read by R/I/load/store/branch/jalr.
  - rs2 is read by R/store/branch.
- Hazard is forced to 0 when LOAD_BUBBLES=0.
- flush:
  - Next state is EMPTY, counter=0, out_valid=0 next cycle.
  - in_ready=0 in the flush cycle.
  - flush overrides a simultaneous accept or hazard.
- Illegal instruction: out_illegal=1, regwrite=memwrite=memread=0, out_br_sel=0; still presented as valid.
- x0 destination: regwrite is still asserted (EX/WB ignores writes to rd=0); no hazard is raised on rd=0.
- imm formats: U = instr[31:12]<<12; B and J LSB is 0; all formats sign-extended from instr[31].
- Reset mid-stall: returns to EMPTY immediately; no bubble is emitted after reset.

Optional Feature:
- Macro: DECODE_MEXT_EN.
- Defined: opcode 0110011 with funct7=0000001 decodes as an R-type with out_is_muldiv=1, regwrite=1, aluop=2'b10.
- Undefined: out_is_muldiv is tied 0 and that encoding raises out_illegal=1.

Decomposition:
- Shared package/include (extend orders.vh):
  - opcode constants: r_type, i_type, load, store, b_type, jal, jalr, lui, auipc.
  - funct7 MULDIV constant.
  - aluop encodings.
  - br_sel bit positions.
  - FSM state encodings.
- One sub-module: decode_ctrl_comb, the pure combinational decoder (control bundle, imm, rs-used flags), instantiated once.

Test Plan:
- add x3,x1,x2 (0x002081B3), out_ready=1 → next cycle out_valid=1, regwrite=1, aluop=10, rd=3, rs1=1, rs2=2, illegal=0.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x5 (0x00528333), LOAD_BUBBLES=1:
  - lw presented with memread=1, rw_type=010;
  - exactly one out_valid=0 cycle follows;
  - add is then presented;
  - in_ready=0 during the hazard cycle.
- Same pair with LOAD_BUBBLES=2 → two bubble cycles.
- Same pair with rd=0 (lw x0) → no bubble.
- beq x1,x2,+8 (0x00208463) held with out_ready=0 for 3 cycles → outputs stable, br_sel=000001, imm=8, in_ready=0.
- Then flush → out_valid=0 next cycle.
- Instruction 0x00000000 → out_illegal=1, regwrite=0, memwrite=0.
- mul x3,x1,x2 (0x022081B3):
  - with DECODE_MEXT_EN → is_muldiv=1, illegal=0;
  - without → illegal=1.
- rst asserted during BUBBLE → next cycle out_valid=0, state EMPTY, in_ready=1 once rst deasserts.
